orientation_sequencer: RTL and testbench
========================================

# orientation_sequencer

Upstream control stage for `orientation_math`. On `start` it captures the rover's current polar location from the ultrasound locator and drives the rover straight forward for a fixed time. It then lets the rover settle, captures the new location, and hands both samples to `orientation_math` with a one-cycle enable. It reports the resulting 5-bit orientation (15° units, 0–23), or an error flag if any wait times out.

## Interface
Parameters:
- `MOVE_CYCLES`, default 27_000_000: cycles `move_forward` is held high (1 s at 27 MHz).
- `SETTLE_CYCLES`, default 13_500_000: cycles waited after the move before sampling again.
- `TIMEOUT_CYCLES`, default 54_000_000: maximum wait in any sample or math state.
- `COUNT_W`, default 27: counter width; must hold the largest of the three cycle parameters.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a measurement; sampled only in IDLE.
- `location_valid` in 1: one-cycle strobe, `location` is valid.
- `location` in 12: r [7:0], theta index [11:8].
- `math_done` in 1: `done` from `orientation_math`, a level signal.
- `math_orientation` in 5: `orientation` from `orientation_math`.
- `r_theta_original` out 12: registered first sample.
- `r_theta_final` out 12: registered second sample.
- `math_enable` out 1: one-cycle pulse to `orientation_math`.
- `move_forward` out 1: drive command to the rover transmitter.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `error` out 1: valid with `done`; 1 means the run timed out.
- `orientation` out 5: last successful result; held otherwise.

## Operation
- States: IDLE, SAMPLE_ORIG, MOVE, SETTLE, SAMPLE_FINAL, MATH_START, MATH_WAIT, REPORT.
- **IDLE:** if `start` is high, load the timeout counter and go to SAMPLE_ORIG.
- **SAMPLE_ORIG:** on `location_valid` with theta ≤ 5, register `location` into `r_theta_original` and go to MOVE.
  - A sample with theta > 5 is discarded and the state keeps waiting.
  - If the timeout expires, go to REPORT with error=1.
- **MOVE:** `move_forward`=1 for exactly MOVE_CYCLES cycles, then go to SETTLE.
- **SETTLE:** wait SETTLE_CYCLES cycles with `move_forward`=0. `location_valid` is ignored in MOVE and SETTLE.
- **SAMPLE_FINAL:** same rules as SAMPLE_ORIG, writing `r_theta_final`; a good sample goes to MATH_START.
- **MATH_START:** `math_enable`=1 for one cycle, reload the timeout counter, go to MATH_WAIT.
- **MATH_WAIT:** wait for a rising edge of `math_done` (`math_done` & ~previous `math_done`).
  - A level left high from the previous run must not be accepted.
  - On the edge, latch `math_orientation` into `orientation` and go to REPORT with error=0.
  - If the timeout expires, go to REPORT with error=1.
- **REPORT:** `done`=1 for one cycle with `error` valid, then go to IDLE.
- `start` while `busy` is ignored; `start` held high at REPORT→IDLE begins a new run.
- Reset state: IDLE. Every output is 0, including `orientation`, both `r_theta` registers and the previous-`math_done` register.
- Reset mid-run drops `move_forward` at the reset edge and makes no `done` pulse.
- `error` holds its value until the next REPORT.

## Timing
- `start` seen at edge t0 puts the block in SAMPLE_ORIG from t0+1.
- A valid sample at edge t gives `r_theta_original` updated and `move_forward`=1 at t+1; `move_forward` stays high for MOVE_CYCLES cycles.
- SETTLE lasts SETTLE_CYCLES cycles.
- A final sample at edge t gives `math_enable`=1 in cycle t+1 and MATH_WAIT from t+2.
- A `math_done` rise at edge t gives the `orientation` update and `done` pulse at t+1. `orientation` changes only in the same cycle `done` rises.
- Timeout: if the awaited event has not come after TIMEOUT_CYCLES cycles in a wait state, REPORT/`done` occurs on the next cycle.
- An event arriving on the same edge the counter expires is treated as success.
- Counters saturate at 0; a cycle parameter of 0 is treated as 1.
- Run latency without waits: 6 + MOVE_CYCLES + SETTLE_CYCLES + math latency.

## Structure
- Shared package `radar_pkg` holds:
  - the field slices R_MSB=7 and THETA_LSB=8, THETA_MSB=11;
  - THETA_MAX=5 and ORIENT_W=5;
  - the state encodings.
- One sub-module, `cycle_timer`: inputs load and load_value[COUNT_W-1:0]; output expired.
  - It decrements once per cycle and is reused for move, settle and timeout, since these are mutually exclusive in time.

## Test plan
All scenarios use MOVE_CYCLES=8, SETTLE_CYCLES=4, TIMEOUT_CYCLES=32, with a behavioural `orientation_math` model.
- **Nominal run:** `start`, then `location`=0x150, move, then `location`=0x180 → `r_theta_original`=0x150, `r_theta_final`=0x180, `move_forward` high exactly 8 cycles, one `math_enable` pulse. Model returns 5 → `orientation`=5, `done` pulse with error=0.
- **Invalid theta:** `location`=0x640 strobed in SAMPLE_ORIG → ignored; a later 0x240 is captured.
- **Stale done:** `math_done` held 1 from the previous run through MATH_START → not accepted; the next fall then rise of `math_done` is accepted.
- **Timeout:** no `location_valid` after `start` → after 32 cycles, `done`=1, error=1, `orientation` unchanged, IDLE.
- **Reset mid-MOVE:** reset at move cycle 3 → `move_forward`=0 and all outputs 0 after that edge, no `done` pulse; a following `start` runs normally.
- **Ignored inputs:** `start` pulsed in SETTLE and `location_valid` pulsed in MOVE → no effect on state or captured values.

Source files
------------

// File: rtl/radar_pkg.sv
// Shared constants and state encoding for the rover radar / orientation control path.
package radar_pkg;

  localparam int R_MSB     = 7;
  localparam int THETA_LSB = 8;
  localparam int THETA_MSB = 11;
  localparam int THETA_MAX = 5;
  localparam int ORIENT_W  = 5;
  localparam int LOC_W     = THETA_MSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE_ORIG,
    MOVE,
    SETTLE,
    SAMPLE_FINAL,
    MATH_START,
    MATH_WAIT,
    REPORT
  } seq_state_t;

  // Samples with a theta index beyond THETA_MAX are outside the locator's usable sector.
  function automatic logic theta_ok(input logic [LOC_W-1:0] loc);
    return loc[THETA_MSB:THETA_LSB] <= 4'(THETA_MAX);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counter shared by the move, settle and timeout waits; expired marks the last cycle of a wait.
module cycle_timer #(
  parameter int COUNT_W = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  output logic               expired
);

  logic [COUNT_W-1:0] count;

  // A load of 0 behaves as 1 so every wait lasts at least one cycle; the count saturates at 0.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= (load_value == '0) ? COUNT_W'(1) : load_value;
    else if (count != '0)
      count <= count - COUNT_W'(1);
  end

  assign expired = (count <= COUNT_W'(1));

endmodule

// File: rtl/orientation_sequencer.sv
// Sequences sample / move / settle / sample / math for orientation_math and reports the result.
module orientation_sequencer
  import radar_pkg::*;
#(
  parameter int MOVE_CYCLES    = 27_000_000,
  parameter int SETTLE_CYCLES  = 13_500_000,
  parameter int TIMEOUT_CYCLES = 54_000_000,
  parameter int COUNT_W        = 27
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                location_valid,
  input  logic [THETA_MSB:0]  location,
  input  logic                math_done,
  input  logic [ORIENT_W-1:0] math_orientation,
  output logic [THETA_MSB:0]  r_theta_original,
  output logic [THETA_MSB:0]  r_theta_final,
  output logic                math_enable,
  output logic                move_forward,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ORIENT_W-1:0] orientation
);

  localparam logic [COUNT_W-1:0] MOVE_LD    = COUNT_W'(MOVE_CYCLES);
  localparam logic [COUNT_W-1:0] SETTLE_LD  = COUNT_W'(SETTLE_CYCLES);
  localparam logic [COUNT_W-1:0] TIMEOUT_LD = COUNT_W'(TIMEOUT_CYCLES);

  seq_state_t         state, state_next;
  logic               timer_load;
  logic [COUNT_W-1:0] timer_value;
  logic               timer_expired;
  logic               math_done_q;
  logic               loc_good;
  logic               done_rise;
  logic               cap_orig, cap_final, latch_orient;
  logic               go_report, report_error;

  assign loc_good  = location_valid && theta_ok(location);
  assign done_rise = math_done && !math_done_q;

  cycle_timer #(.COUNT_W(COUNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Awaited events take priority over timer expiry, so a last-cycle arrival counts as success.
  always_comb begin
    state_next   = state;
    timer_load   = 1'b0;
    timer_value  = TIMEOUT_LD;
    cap_orig     = 1'b0;
    cap_final    = 1'b0;
    latch_orient = 1'b0;
    go_report    = 1'b0;
    report_error = 1'b0;
    case (state)
      IDLE: if (start) begin
        timer_load = 1'b1;
        state_next = SAMPLE_ORIG;
      end
      SAMPLE_ORIG: if (loc_good) begin
        cap_orig    = 1'b1;
        timer_load  = 1'b1;
        timer_value = MOVE_LD;
        state_next  = MOVE;
      end else if (timer_expired) begin
        go_report    = 1'b1;
        report_error = 1'b1;
        state_next   = REPORT;
      end
      MOVE: if (timer_expired) begin
        timer_load  = 1'b1;
        timer_value = SETTLE_LD;
        state_next  = SETTLE;
      end
      SETTLE: if (timer_expired) begin
        timer_load = 1'b1;
        state_next = SAMPLE_FINAL;
      end
      SAMPLE_FINAL: if (loc_good) begin
        cap_final  = 1'b1;
        state_next = MATH_START;
      end else if (timer_expired) begin
        go_report    = 1'b1;
        report_error = 1'b1;
        state_next   = REPORT;
      end
      MATH_START: begin
        timer_load = 1'b1;
        state_next = MATH_WAIT;
      end
      MATH_WAIT: if (done_rise) begin
        latch_orient = 1'b1;
        go_report    = 1'b1;
        state_next   = REPORT;
      end else if (timer_expired) begin
        go_report    = 1'b1;
        report_error = 1'b1;
        state_next   = REPORT;
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_theta_original <= '0;
      r_theta_final    <= '0;
      orientation      <= '0;
      error            <= 1'b0;
      math_done_q      <= 1'b0;
    end else begin
      math_done_q <= math_done;
      if (cap_orig)     r_theta_original <= location;
      if (cap_final)    r_theta_final    <= location;
      if (latch_orient) orientation      <= math_orientation;
      if (go_report)    error            <= report_error;
    end
  end

  assign busy         = (state != IDLE);
  assign move_forward = (state == MOVE);
  assign math_enable  = (state == MATH_START);
  assign done         = (state == REPORT);

endmodule

// File: tb/tb_orientation_sequencer.sv
// Randomized run-level bench for orientation_sequencer with a behavioural orientation_math stand-in.
module tb_orientation_sequencer;

  localparam int MOVE_C   = 8;
  localparam int SETTLE_C = 4;
  localparam int TMO_C    = 32;

  logic        clock = 1'b0;
  logic        reset, start, location_valid, math_done;
  logic [11:0] location;
  logic [4:0]  math_orientation;
  logic [11:0] r_theta_original, r_theta_final;
  logic        math_enable, move_forward, busy, done, error;
  logic [4:0]  orientation;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [4:0]  orient_m;
  logic        err_m;

  orientation_sequencer #(
    .MOVE_CYCLES    (MOVE_C),
    .SETTLE_CYCLES  (SETTLE_C),
    .TIMEOUT_CYCLES (TMO_C),
    .COUNT_W        (27)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .location_valid   (location_valid),
    .location         (location),
    .math_done        (math_done),
    .math_orientation (math_orientation),
    .r_theta_original (r_theta_original),
    .r_theta_final    (r_theta_final),
    .math_enable      (math_enable),
    .move_forward     (move_forward),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .orientation      (orientation)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] good_loc();
    logic [11:0] v;
    v[11:8] = 4'($urandom_range(0, 5));
    v[7:0]  = 8'($urandom);
    return v;
  endfunction

  function automatic logic [11:0] bad_loc();
    logic [11:0] v;
    v[11:8] = 4'($urandom_range(6, 15));
    v[7:0]  = 8'($urandom);
    return v;
  endfunction

  // Present the good sample in cycle 'delay' of the wait (invalid-theta noise before it);
  // n returns the cycle index at which the stage was seen to leave.
  task automatic sample_phase(input logic [11:0] good, input int delay, input bit final_stage,
                              output int n);
    bit stop;
    stop = 1'b0;
    n = 0;
    while (!stop && n < 100) begin
      @(negedge clock);
      start = 1'b0;
      location_valid = 1'b0;
      if (n == delay) begin
        location_valid = 1'b1;
        location = good;
      end else if (n < delay && (n == 0 || $urandom_range(0, 1) == 1)) begin
        location_valid = 1'b1;
        location = (n == 0) ? 12'h640 : bad_loc();
      end
      @(posedge clock); #1;
      n++;
      stop = done || (final_stage ? math_enable : move_forward);
    end
  endtask

  task automatic report_check(input bit exp_err);
    check("done_pulse", done, 1);
    check("report_error", error, exp_err);
    check("report_orient", orientation, orient_m);
    err_m = exp_err;
    @(negedge clock);
    start = 1'b0;
    location_valid = 1'b0;
    @(posedge clock); #1;
    check("done_single", done, 0);
    check("back_idle", busy, 0);
  endtask

  task automatic run(input logic [11:0] orig, input int d0, input logic [11:0] fin, input int d1,
                     input int lat, input bit stale, input logic [4:0] res, input int rst_move);
    int n, m, sp, pulse_at, k_exp;
    bit got;
    logic [11:0] decoy;
    check("idle_busy", busy, 0);
    check("idle_error_hold", error, err_m);
    check("idle_orient_hold", orientation, orient_m);
    @(negedge clock);
    start = 1'b1;
    location_valid = 1'b0;
    if (stale) math_done = 1'b1;
    @(posedge clock); #1;
    check("start_busy", busy, 1);

    sample_phase(orig, d0, 1'b0, n);
    if (d0 >= TMO_C) begin
      check("orig_timeout_cycles", n, TMO_C);
      report_check(1'b1);
      return;
    end
    check("orig_latency", n, d0 + 1);
    check("orig_capture", r_theta_original, orig);
    check("move_on", move_forward, 1);

    m = 1;
    pulse_at = $urandom_range(1, MOVE_C - 1);
    while (move_forward && m < 100) begin
      @(negedge clock);
      start = 1'b0;
      location_valid = 1'b0;
      if (m == pulse_at) begin
        location_valid = 1'b1;
        location = good_loc();
      end
      if (rst_move != 0 && m == rst_move) reset = 1'b1;
      @(posedge clock); #1;
      if (reset) begin
        check("rst_move_forward", move_forward, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_orient", orientation, 0);
        check("rst_orig", r_theta_original, 0);
        check("rst_final", r_theta_final, 0);
        check("rst_math_enable", math_enable, 0);
        @(negedge clock);
        reset = 1'b0;
        orient_m = '0;
        err_m = 1'b0;
        return;
      end
      if (move_forward) m++;
    end
    check("move_cycles", m, MOVE_C);

    sp = $urandom_range(0, SETTLE_C - 2);
    decoy = fin ^ 12'h001;
    for (int s = 0; s < SETTLE_C; s++) begin
      @(negedge clock);
      start = (s == sp);
      location_valid = 1'b0;
      if (s == SETTLE_C - 1) begin
        location_valid = 1'b1;
        location = decoy;
      end
      @(posedge clock); #1;
      if (s == sp) check("settle_ignores_start", move_forward | done | math_enable, 0);
    end
    check("orig_unchanged", r_theta_original, orig);

    sample_phase(fin, d1, 1'b1, n);
    if (d1 >= TMO_C) begin
      check("final_timeout_cycles", n, TMO_C);
      report_check(1'b1);
      return;
    end
    check("final_latency", n, d1 + 1);
    check("final_capture", r_theta_final, fin);
    check("math_enable_on", math_enable, 1);

    // Stand-in for orientation_math: done falls after enable (or late, when stale) and rises after lat cycles.
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clock);
      start = 1'b0;
      location_valid = 1'b0;
      if (n == (stale ? lat - 1 : 0)) math_done = 1'b0;
      if (n == lat) begin
        math_done = 1'b1;
        math_orientation = res;
      end
      @(posedge clock); #1;
      n++;
      if (done) got = 1'b1;
      else begin
        check("math_enable_once", math_enable, 0);
        check("orient_hold_wait", orientation, orient_m);
      end
    end
    k_exp = (lat <= TMO_C) ? lat + 1 : TMO_C + 1;
    check("math_latency", n, k_exp);
    if (lat <= TMO_C) orient_m = res;
    report_check(lat > TMO_C);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    location_valid = 1'b0;
    location = '0;
    math_done = 1'b0;
    math_orientation = '0;
    orient_m = '0;
    err_m = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_move", move_forward, 0);
    check("reset_orient", orientation, 0);
    check("reset_orig", r_theta_original, 0);
    check("reset_final", r_theta_final, 0);
    @(negedge clock);
    reset = 1'b0;

    run(12'h150, 0, 12'h180, 0, 3, 1'b0, 5'd5, 0);
    run(12'h240, 1, good_loc(), 2, 4, 1'b0, 5'd9, 0);
    run(good_loc(), 0, good_loc(), 0, 6, 1'b1, 5'd17, 0);
    run(good_loc(), 40, good_loc(), 0, 3, 1'b0, 5'd1, 0);
    run(good_loc(), 0, good_loc(), 0, 3, 1'b0, 5'd2, 3);
    run(good_loc(), 0, good_loc(), 0, 3, 1'b0, 5'd23, 0);
    run(good_loc(), 31, good_loc(), 31, 32, 1'b0, 5'd11, 0);
    run(good_loc(), 0, good_loc(), 0, 33, 1'b0, 5'd7, 0);
    run(good_loc(), 2, good_loc(), 40, 3, 1'b0, 5'd4, 0);
    for (int i = 0; i < 14; i++) begin
      run(good_loc(), $urandom_range(0, 6), good_loc(), $urandom_range(0, 6),
          $urandom_range(2, 10), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 23)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
